// File: rtl/accel_pkg.sv
// Shared definitions for the convolution accelerator and its instruction sequencer.
// Holds the sequencer opcode constants, the sequencer FSM state encoding and the
// derived-width functions, so the accelerator top and the sequencer agree on the
// instruction word layout.
package accel_pkg;

  localparam logic [3:0] OP_HALT       = 4'hF;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'hE;
  localparam logic [3:0] OP_LOOP_END   = 4'hD;
  localparam logic [3:0] OP_WAIT       = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RUN     = 3'd2,
    ST_WAITCNT = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  // Index-field width: max(2, depth).
  function automatic int ins_w(input int depth);
    return (depth > 2) ? depth : 2;
  endfunction

  // Data/count-field width: max(2^depth, W).
  function automatic int ins_d(input int depth, input int w);
    int d;
    d = 1 << depth;
    return (d > w) ? d : w;
  endfunction

  // Full instruction width: opcode(4) + 2 flag bits + two index fields + data field.
  function automatic int ins_width(input int depth, input int w);
    return 4 + 2 + 2 * ins_w(depth) + ins_d(depth, w);
  endfunction

endpackage

// File: rtl/program_ram.sv
// Single-port synchronous program RAM, 2^AW words of DW bits.
// One shared address: the owner muxes host writes and sequencer reads onto it.
// Read data appears one cycle after the address (registered read port).
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata at addr)
//   addr  - read/write address
//   wdata - write data
//   rdata - registered read data for the address of the previous cycle
module program_ram #(
  parameter int AW = 8,
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage write and registered read; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Program-driven front end for the convolution accelerator. Issues one word per
// cycle from a host-loaded program RAM, consuming sequencer opcodes (HALT, WAIT,
// LOOP_BEGIN, LOOP_END) internally.
// Optional feature macro: INSTR_SEQ_LOOP_EN enables the single-level hardware loop;
// without it LOOP_BEGIN/LOOP_END are plain one-slot bubbles.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   progWrite/Addr/Data - host program load (accepted only while idle)
//   start             - begin execution at address 0 (idle only, clears error)
//   stall             - accelerator back-pressure on valid words
//   instruction       - word to the accelerator (0 unless instrValid)
//   instrValid        - instruction is meaningful this cycle
//   busy, done, error - status: running, end-of-run pulse, sticky fault
//   pc                - address of the word in the issue slot
//
// The issue slot is the RAM read register itself: the read address is steered to
// pc+1 when the slot empties and to pc while it holds, so stalls cost no refetch.
module instruction_sequencer
  import accel_pkg::*;
#(
  parameter  int depth    = 3,
  parameter  int W        = 16,
  parameter  int PA       = 8,
  localparam int insD     = ins_d(depth, W),
  localparam int insWidth = ins_width(depth, W)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                progWrite,
  input  logic [PA-1:0]       progAddr,
  input  logic [insWidth-1:0] progData,
  input  logic                start,
  input  logic                stall,
  output logic [insWidth-1:0] instruction,
  output logic                instrValid,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [PA-1:0]       pc
);

  localparam logic [PA-1:0]   PC_ONE   = {{(PA-1){1'b0}}, 1'b1};
  localparam logic [PA-1:0]   PC_LAST  = {PA{1'b1}};
  localparam logic [insD-1:0] CNT_ZERO = {insD{1'b0}};
  localparam logic [insD-1:0] CNT_ONE  = {{(insD-1){1'b0}}, 1'b1};

  seq_state_t          state;
  logic [insD-1:0]     wait_cnt;
  logic [insWidth-1:0] rdata;
  logic [PA-1:0]       raddr;
  logic [PA-1:0]       ram_addr;
  logic                ram_we;
  logic [3:0]          opcode;
  logic [insD-1:0]     count;
  logic                is_seq;
  logic                in_run;
  logic                slot_leaves;
  logic                at_last;
  logic                loop_fault;

  assign opcode = rdata[insWidth-1 -: 4];
  assign count  = rdata[insD-1:0];

  program_ram #(.AW(PA), .DW(insWidth)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (progData),
    .rdata (rdata)
  );

  // Slot decode, issue outputs and RAM address steering.
  always_comb begin
    is_seq = (opcode == OP_HALT) || (opcode == OP_LOOP_BEGIN) ||
             (opcode == OP_LOOP_END) || (opcode == OP_WAIT);
    in_run      = (state == ST_RUN);
    instrValid  = in_run && !is_seq;
    instruction = instrValid ? rdata : {insWidth{1'b0}};
    // Sequencer slots are bubbles to the accelerator, so stall never holds them.
    slot_leaves = in_run && (is_seq || !stall);
    at_last     = (pc == PC_LAST);
    ram_we      = (state == ST_IDLE) && progWrite;
    if (slot_leaves) begin
      raddr = pc + PC_ONE;
    end else begin
      raddr = pc;
    end
    if (ram_we) begin
      ram_addr = progAddr;
    end else begin
      ram_addr = raddr;
    end
  end

`ifdef INSTR_SEQ_LOOP_EN
  logic            loop_active;
  logic [PA-1:0]   loop_start;
  logic [insD-1:0] loop_rem;

  // Nested LOOP_BEGIN and orphan LOOP_END are faults.
  always_comb begin
    loop_fault = ((opcode == OP_LOOP_BEGIN) && loop_active) ||
                 ((opcode == OP_LOOP_END) && !loop_active);
  end
`else
  // Without the loop feature the loop opcodes cannot fault.
  always_comb begin
    loop_fault = 1'b0;
  end
`endif

  // Sequencer FSM with registered status, pc, wait and loop counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      pc       <= {PA{1'b0}};
      wait_cnt <= CNT_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
      loop_active <= 1'b0;
      loop_start  <= {PA{1'b0}};
      loop_rem    <= CNT_ZERO;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= {PA{1'b0}};
            busy  <= 1'b1;
            error <= 1'b0;
`ifdef INSTR_SEQ_LOOP_EN
            loop_active <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (slot_leaves) begin
            if (opcode == OP_HALT) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (at_last || loop_fault) begin
              // The last word has issued (or a loop fault hit); never wrap pc.
              state <= ST_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (opcode == OP_WAIT) begin
              pc <= pc + PC_ONE;
              if (count != CNT_ZERO) begin
                wait_cnt <= count - CNT_ONE;
                state    <= ST_WAITCNT;
              end
`ifdef INSTR_SEQ_LOOP_EN
            end else if (opcode == OP_LOOP_BEGIN) begin
              loop_active <= 1'b1;
              loop_start  <= pc + PC_ONE;
              loop_rem    <= (count == CNT_ZERO) ? CNT_ONE : count;
              pc          <= pc + PC_ONE;
            end else if ((opcode == OP_LOOP_END) && (loop_rem > CNT_ONE)) begin
              // Jump back: FETCH is the single refetch bubble.
              loop_rem <= loop_rem - CNT_ONE;
              pc       <= loop_start;
              state    <= ST_FETCH;
            end else if (opcode == OP_LOOP_END) begin
              loop_active <= 1'b0;
              pc          <= pc + PC_ONE;
`endif
            end else begin
              pc <= pc + PC_ONE;
            end
          end
        end
        ST_WAITCNT: begin
          if (wait_cnt == CNT_ZERO) begin
            state <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. A program interpreter expands the
// loaded program into the expected stream of issue slots (valid words and bubble
// runs) plus the expected error flag; the bench then walks that stream cycle by
// cycle under directed or random stall and compares the DUT outputs.
module tb_instruction_sequencer;

  localparam int PA = 8;
  localparam int IW = 28;
  localparam int NW = 1 << PA;

  logic          CLK = 1'b0;
  logic          RST;
  logic          progWrite;
  logic [PA-1:0] progAddr;
  logic [IW-1:0] progData;
  logic          start;
  logic          stall;
  logic [IW-1:0] instruction;
  logic          instrValid;
  logic          busy;
  logic          done;
  logic          error;
  logic [PA-1:0] pc;

  always #5 CLK = ~CLK;

  instruction_sequencer #(.depth(3), .W(16), .PA(PA)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .progWrite   (progWrite),
    .progAddr    (progAddr),
    .progData    (progData),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .instrValid  (instrValid),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .pc          (pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [IW-1:0] prog [0:NW-1];
  bit            q_valid [$];
  logic [IW-1:0] q_word  [$];
  int            q_pc    [$];
  int            q_len   [$];
  bit            exp_err;

  int stall_mode = 0;
  int scribble   = 0;
  int rel        = 0;

  function automatic void push_word(input logic [IW-1:0] w, input int p);
    q_valid.push_back(1'b1); q_word.push_back(w); q_pc.push_back(p); q_len.push_back(1);
  endfunction

  function automatic void push_bubble(input int len);
    q_valid.push_back(1'b0); q_word.push_back('0); q_pc.push_back(0); q_len.push_back(len);
  endfunction

  // Interpret the program: what the accelerator sees, slot by slot.
  function automatic void build_expect();
    int p = 0; bit act = 0; int lstart = 0; int rem = 0;
    logic [IW-1:0] w; logic [3:0] op; int cnt;
    q_valid.delete(); q_word.delete(); q_pc.delete(); q_len.delete();
    exp_err = 1'b0;
    for (int guard = 0; guard < 4000; guard++) begin
      w = prog[p]; op = w[IW-1 -: 4]; cnt = int'(w[15:0]);
      if (op == 4'hF) begin push_bubble(1); return; end
      if (p == NW - 1) begin
        if (op < 4'hC) push_word(w, p); else push_bubble(1);
        exp_err = 1'b1; return;
      end
      if (op < 4'hC) begin push_word(w, p); p++; end
      else if (op == 4'hC) begin push_bubble(1 + cnt); p++; end
`ifdef INSTR_SEQ_LOOP_EN
      else if (op == 4'hE) begin
        push_bubble(1);
        if (act) begin exp_err = 1'b1; return; end
        act = 1; lstart = p + 1; rem = (cnt == 0) ? 1 : cnt; p++;
      end else begin
        if (!act) begin push_bubble(1); exp_err = 1'b1; return; end
        if (rem > 1) begin rem--; push_bubble(2); p = lstart; end
        else begin act = 0; push_bubble(1); p++; end
      end
`else
      else begin push_bubble(1); p++; end
`endif
    end
  endfunction

  task automatic write_word(input int a, input logic [IW-1:0] d);
    @(negedge CLK);
    progWrite = 1'b1; progAddr = PA'(a); progData = d; prog[a] = d;
  endtask

  // Advance to the middle of the next cycle and drive that cycle's inputs.
  task automatic next_cycle();
    @(negedge CLK);
    rel++;
    case (stall_mode)
      1:       stall = ($urandom_range(0, 2) == 0);
      2:       stall = (rel >= 3 && rel <= 5);
      default: stall = 1'b0;
    endcase
    if (scribble != 0) begin
      progWrite = ($urandom_range(0, 1) == 1);
      progAddr  = PA'($urandom_range(0, NW - 1));
      progData  = IW'($urandom);
      start     = ($urandom_range(0, 3) == 0);
    end else begin
      progWrite = 1'b0;
      start     = 1'b0;
    end
  endtask

  task automatic run_prog(input int smode, input int scrib);
    int held;
    build_expect();
    stall_mode = smode; scribble = 0;
    @(negedge CLK);
    rel = 0; start = 1'b1; stall = 1'b0; progWrite = 1'b0;
    next_cycle();
    check_eq("fetch_busy", 32'(busy), 32'd1);
    check_eq("fetch_valid", 32'(instrValid), 32'd0);
    check_eq("start_clears_error", 32'(error), 32'd0);
    scribble = scrib;
    for (int i = 0; i < q_valid.size(); i++) begin
      if (q_valid[i]) begin
        held = 0;
        do begin
          next_cycle();
          if (held >= 8) stall = 1'b0;
          check_eq("word_valid", 32'(instrValid), 32'd1);
          check_eq("word", 32'(instruction), 32'(q_word[i]));
          check_eq("word_pc", 32'(pc), 32'(q_pc[i]));
          held++;
        end while (stall);
      end else begin
        for (int k = 0; k < q_len[i]; k++) begin
          next_cycle();
          check_eq("bubble_valid", 32'(instrValid), 32'd0);
          check_eq("bubble_instr", 32'(instruction), 32'd0);
          check_eq("bubble_busy", 32'(busy), 32'd1);
        end
      end
    end
    next_cycle();
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd1);
    check_eq("done_valid", 32'(instrValid), 32'd0);
    check_eq("done_error", 32'(error), 32'(exp_err));
    next_cycle();
    start = 1'b0; progWrite = 1'b0; stall = 1'b0; scribble = 0;
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_error", 32'(error), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_instr"}, 32'(instruction), 32'd0);
    check_eq({tag, "_valid"}, 32'(instrValid), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  task automatic load_loop_prog();
    write_word(0, {4'hE, 8'h00, 16'd3});
    write_word(1, 28'h1234567);
    write_word(2, 28'h2ABCDEF);
    write_word(3, {4'hD, 24'h0});
    write_word(4, {4'hF, 24'h0});
  endtask

  function automatic logic [IW-1:0] rand_pass();
    logic [23:0] body;
    body = 24'($urandom);
    return {4'($urandom_range(0, 11)), body};
  endfunction

  initial begin
    int len; int r; logic [IW-1:0] w;
    RST = 1'b1; progWrite = 1'b0; progAddr = '0; progData = '0; start = 1'b0; stall = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;

    // A, B, C, HALT without and with a stall window.
    write_word(0, 28'h0A0A0A1);
    write_word(1, 28'h10B0B02);
    write_word(2, 28'hB0C0C03);
    write_word(3, {4'hF, 24'h0});
    run_prog(0, 0);
    run_prog(2, 0);

    // X, WAIT 3, Y, HALT.
    write_word(0, 28'h5555AAA);
    write_word(1, {4'hC, 8'h00, 16'd3});
    write_word(2, 28'h6666BBB);
    write_word(3, {4'hF, 24'h0});
    run_prog(0, 0);
    run_prog(1, 1);

    // Loop program, plain and with random stall plus ignored host traffic.
    load_loop_prog();
    run_prog(0, 0);
    run_prog(1, 1);

    // Orphan LOOP_END, then a valid program clears error.
    write_word(0, {4'hD, 24'h0});
    write_word(1, {4'hF, 24'h0});
    run_prog(0, 0);
    load_loop_prog();
    run_prog(0, 0);

    // Reset mid-loop, then replay.
    @(negedge CLK);
    progWrite = 1'b0; stall_mode = 0; scribble = 0; rel = 0; start = 1'b1;
    next_cycle();
    repeat (6) next_cycle();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("midloop_reset");
    run_prog(1, 0);

    // Reset clears a sticky error.
    write_word(0, {4'hD, 24'h0});
    write_word(1, {4'hF, 24'h0});
    run_prog(0, 0);
    @(negedge CLK);
    progWrite = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("error_reset");

    // Random programs.
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(3, 24);
      for (int a = 0; a < len; a++) begin
        r = $urandom_range(0, 9);
        case (r)
          6:       w = {4'hC, 8'($urandom), 16'($urandom_range(0, 3))};
          7:       w = {4'hE, 8'($urandom), 16'($urandom_range(0, 3))};
          8:       w = {4'hD, 24'($urandom)};
          default: w = rand_pass();
        endcase
        write_word(a, w);
      end
      write_word(len, {4'hF, 24'h0});
      run_prog(1, 1);
    end

    // No HALT anywhere: the last address issues, then a fault.
    for (int a = 0; a < NW; a++) write_word(a, rand_pass());
    run_prog(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
